// File: rtl/parallel_send_gen.sv
// -----------------------------------------------------------------------------
// parallel_send_gen
//
// Link-training transmitter in front of the parallel-link serializer. The
// serializer pulls one word per DOPULL. After reset the block walks
// INIT -> DELAY_ADJUST -> WORD_ALIGN -> DATA_TRANSFER. In DATA_TRANSFER it
// forwards upstream payload, or IDLE_PAT when none is offered. It retrains
// (back to DELAY_ADJUST) after DATA_LEN data pulls, or when RETRAIN is raised.
//
// Optional feature macro: PARALLEL_SEND_TESTGEN_EN
//   When defined, a TEST_MODE input is added. With TEST_MODE=1 the data phase
//   ignores DIN and emits an incrementing DW-bit counter instead.
//
// Handshake: payload is transferred in a cycle where DIN_VALID && DIN_READY.
//   DIN_READY is combinational and is high only while the serializer is pulling
//   in DATA_TRANSFER with no retrain pending. DIN may change freely otherwise.
//
// Ports
//   CLK        clock
//   RST        asynchronous active-high reset
//   CLR        synchronous clear, same effect as RST, overrides every input
//   DOPULL     serializer consumes one word this cycle
//   RETRAIN    retrain request, latched until acted upon
//   DIN        upstream payload word
//   DIN_VALID  DIN holds a valid word
//   TEST_MODE  (PARALLEL_SEND_TESTGEN_EN only) emit counter instead of payload
//   DIN_READY  payload accepted this cycle when DIN_VALID is also high
//   DOPUSH     DOUT valid (one cycle after DOPULL, low for INIT words)
//   DOUT       word to the serializer
//   DOUT_DATA  DOUT carries payload rather than training/idle fill
//   PHY_INIT   PHY delay-adjust window marker
// -----------------------------------------------------------------------------
module parallel_send_gen #(
    parameter int              DW        = 32,
    parameter int              INIT_LEN  = 64,
    parameter int              DELAY_LEN = 256,
    parameter int              GUARD     = 33,
    parameter int              PI_START  = 65,
    parameter int              PI_END    = 191,
    parameter int              ALIGN_LEN = 1,
    parameter int              DATA_LEN  = 1024,
    parameter logic [DW-1:0]   TRAIN_PAT = {(DW/2){2'b10}},
    parameter logic [31:0]     ALIGN_PAT = 32'hF7318CEF,
    parameter logic [DW-1:0]   IDLE_PAT  = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          DOPULL,
    input  logic          RETRAIN,
    input  logic [DW-1:0] DIN,
    input  logic          DIN_VALID,
`ifdef PARALLEL_SEND_TESTGEN_EN
    input  logic          TEST_MODE,
`endif
    output logic          DIN_READY,
    output logic          DOPUSH,
    output logic [DW-1:0] DOUT,
    output logic          DOUT_DATA,
    output logic          PHY_INIT
);

    // Phase index counter is sized for the longest phase so it never wraps.
    localparam int MAX_AB  = (INIT_LEN  > DELAY_LEN) ? INIT_LEN  : DELAY_LEN;
    localparam int MAX_CD  = (ALIGN_LEN > DATA_LEN)  ? ALIGN_LEN : DATA_LEN;
    localparam int MAX_LEN = (MAX_AB    > MAX_CD)    ? MAX_AB    : MAX_CD;
    localparam int KW      = $clog2(MAX_LEN + 1);

    localparam logic [KW-1:0] INIT_LAST  = KW'(INIT_LEN - 1);
    localparam logic [KW-1:0] DELAY_LAST = KW'(DELAY_LEN - 1);
    localparam logic [KW-1:0] ALIGN_LAST = KW'(ALIGN_LEN - 1);
    localparam logic [KW-1:0] DATA_LAST  = (DATA_LEN == 0) ? '0 : KW'(DATA_LEN - 1);
    localparam logic [KW-1:0] TRAIN_LO   = KW'(GUARD);
    localparam logic [KW-1:0] TRAIN_HI   = KW'(DELAY_LEN - GUARD);
    localparam logic [KW-1:0] PI_LO      = KW'(PI_START);
    localparam logic [KW-1:0] PI_HI      = KW'(PI_END);
    localparam logic [DW-1:0] ALIGN_WORD = DW'(ALIGN_PAT);

    typedef enum logic [1:0] {
        ST_INIT          = 2'd0,
        ST_DELAY_ADJUST  = 2'd1,
        ST_WORD_ALIGN    = 2'd2,
        ST_DATA_TRANSFER = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic          retrain_pending, retrain_pending_nx;
    logic [DW-1:0] dout_nx;
    logic          dopush_nx;
    logic          dout_data_nx;
    logic          phy_init_nx;
    logic          test_sel;

`ifdef PARALLEL_SEND_TESTGEN_EN
    logic [DW-1:0] test_cnt, test_cnt_nx;
    assign test_sel = TEST_MODE;
`else
    assign test_sel = 1'b0;
`endif

    // Payload is only taken while a real data word is being emitted.
    assign DIN_READY = DOPULL && !CLR && (state == ST_DATA_TRANSFER) &&
                       !retrain_pending && !test_sel;

    always_comb begin
        state_nx           = state;
        k_nx               = k;
        retrain_pending_nx = retrain_pending;
        dout_nx            = DOUT;
        dopush_nx          = 1'b0;
        dout_data_nx       = DOUT_DATA;
        phy_init_nx        = PHY_INIT;
`ifdef PARALLEL_SEND_TESTGEN_EN
        test_cnt_nx        = test_cnt;
`endif
        if (CLR) begin
            state_nx           = ST_INIT;
            k_nx               = '0;
            retrain_pending_nx = 1'b0;
            dout_nx            = '0;
            dout_data_nx       = 1'b0;
            phy_init_nx        = 1'b0;
`ifdef PARALLEL_SEND_TESTGEN_EN
            test_cnt_nx        = DW'(1);
`endif
        end else begin
            // A request only matters while data is flowing; training that is
            // already running or about to start absorbs it.
            if (state != ST_DATA_TRANSFER)
                retrain_pending_nx = 1'b0;
            else
                retrain_pending_nx = retrain_pending | RETRAIN;

            if (DOPULL) begin
                k_nx         = k + 1'b1;
                dopush_nx    = 1'b1;
                dout_nx      = '0;
                dout_data_nx = 1'b0;
                phy_init_nx  = 1'b0;
                case (state)
                    ST_INIT: begin
                        dopush_nx = 1'b0;
                        if (k == INIT_LAST) begin
                            state_nx = ST_DELAY_ADJUST;
                            k_nx     = '0;
                        end
                    end
                    ST_DELAY_ADJUST: begin
                        if (k >= TRAIN_LO && k < TRAIN_HI)
                            dout_nx = TRAIN_PAT;
                        phy_init_nx = (k >= PI_LO) && (k < PI_HI);
                        if (k == DELAY_LAST) begin
                            state_nx = ST_WORD_ALIGN;
                            k_nx     = '0;
                        end
                    end
                    ST_WORD_ALIGN: begin
                        dout_nx = ALIGN_WORD;
                        if (k == ALIGN_LAST) begin
                            state_nx = ST_DATA_TRANSFER;
                            k_nx     = '0;
                        end
                    end
                    default: begin
                        if (retrain_pending) begin
                            // Empty word marks the break before training.
                            state_nx           = ST_DELAY_ADJUST;
                            k_nx               = '0;
                            retrain_pending_nx = 1'b0;
                        end else begin
                            if (test_sel) begin
`ifdef PARALLEL_SEND_TESTGEN_EN
                                dout_nx      = test_cnt;
                                dout_data_nx = 1'b1;
                                test_cnt_nx  = test_cnt + 1'b1;
`endif
                            end else if (DIN_VALID) begin
                                dout_nx      = DIN;
                                dout_data_nx = 1'b1;
                            end else begin
                                dout_nx = IDLE_PAT;
                            end
                            if (DATA_LEN == 0) begin
                                k_nx = k;
                            end else if (k == DATA_LAST) begin
                                state_nx = ST_DELAY_ADJUST;
                                k_nx     = '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= ST_INIT;
            k               <= '0;
            retrain_pending <= 1'b0;
            DOPUSH          <= 1'b0;
            DOUT            <= '0;
            DOUT_DATA       <= 1'b0;
            PHY_INIT        <= 1'b0;
        end else begin
            state           <= state_nx;
            k               <= k_nx;
            retrain_pending <= retrain_pending_nx;
            DOPUSH          <= dopush_nx;
            DOUT            <= dout_nx;
            DOUT_DATA       <= dout_data_nx;
            PHY_INIT        <= phy_init_nx;
        end
    end

`ifdef PARALLEL_SEND_TESTGEN_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            test_cnt <= DW'(1);
        else
            test_cnt <= test_cnt_nx;
    end
`endif

endmodule

// File: tb/tb_parallel_send_gen.sv
module tb_parallel_send_gen;

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    logic        CLK = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        CLR = 1'b0;
    logic        DOPULL = 1'b0;
    logic        RETRAIN = 1'b0;
    logic [31:0] DIN = '0;
    logic        DIN_VALID = 1'b0;

    always #5 CLK = ~CLK;

    // instance A: default parameters
    logic        ready_a, push_a, data_a, phy_a;
    logic [31:0] dout_a;
    // instance B: small configuration, never auto-retrains
    logic        ready_b, push_b, data_b, phy_b;
    logic [15:0] dout_b;

    parallel_send_gen u_dut_a (
        .CLK(CLK), .RST(rst_a), .CLR(CLR), .DOPULL(DOPULL), .RETRAIN(RETRAIN),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(ready_a), .DOPUSH(push_a),
        .DOUT(dout_a), .DOUT_DATA(data_a), .PHY_INIT(phy_a)
    );

    parallel_send_gen #(
        .DW(16), .INIT_LEN(4), .DELAY_LEN(8), .GUARD(2), .PI_START(2), .PI_END(6),
        .ALIGN_LEN(3), .DATA_LEN(0)
    ) u_dut_b (
        .CLK(CLK), .RST(rst_b), .CLR(CLR), .DOPULL(DOPULL), .RETRAIN(RETRAIN),
        .DIN(DIN[15:0]), .DIN_VALID(DIN_VALID), .DIN_READY(ready_b), .DOPUSH(push_b),
        .DOUT(dout_b), .DOUT_DATA(data_b), .PHY_INIT(phy_b)
    );

    bit sel = 1'b0;  // 0: observe A, 1: observe B

    function automatic logic [31:0] obs_dout();
        return sel ? {16'h0, dout_b} : dout_a;
    endfunction
    function automatic logic obs_push();  return sel ? push_b  : push_a;  endfunction
    function automatic logic obs_data();  return sel ? data_b  : data_a;  endfunction
    function automatic logic obs_phy();   return sel ? phy_b   : phy_a;   endfunction
    function automatic logic obs_ready(); return sel ? ready_b : ready_a; endfunction

    // ------------------------------------------------------------------
    // checking
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // reference model: phase lengths in a table, words from the phase rules
    // phases: 0 INIT, 1 DELAY_ADJUST, 2 WORD_ALIGN, 3 DATA_TRANSFER
    // ------------------------------------------------------------------
    int          m_len[4];
    int          m_guard, m_pi_s, m_pi_e;
    logic [31:0] m_mask, m_train, m_align, m_idle;

    int          ph;
    int          kk;
    bit          pend;
    logic [31:0] e_dout;
    bit          e_push, e_data, e_phy;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        ph = 0; kk = 0; pend = 0;
        e_dout = '0; e_push = 0; e_data = 0; e_phy = 0;
        exp_q.delete();
    endtask

    task automatic set_params_a();
        m_len = '{64, 256, 1, 1024};
        m_guard = 33; m_pi_s = 65; m_pi_e = 191;
        m_mask = 32'hFFFF_FFFF; m_train = 32'hAAAA_AAAA; m_align = 32'hF731_8CEF; m_idle = 0;
    endtask

    task automatic set_params_b();
        m_len = '{4, 8, 3, 0};
        m_guard = 2; m_pi_s = 2; m_pi_e = 6;
        m_mask = 32'h0000_FFFF; m_train = 32'h0000_AAAA; m_align = 32'h0000_8CEF; m_idle = 0;
    endtask

    task automatic model_step(input bit p, input bit r, input bit v, input bit c,
                              input logic [31:0] d);
        int  old_ph;
        bit  adv;
        old_ph = ph;
        if (c) begin
            model_reset();
        end else begin
            if (p) begin
                e_push = 1; e_data = 0; e_phy = 0; e_dout = '0; adv = 1;
                case (ph)
                    0: e_push = 0;
                    1: begin
                        if (kk >= m_guard && kk < m_len[1] - m_guard) e_dout = m_train;
                        e_phy = (kk >= m_pi_s) && (kk < m_pi_e);
                    end
                    2: e_dout = m_align;
                    default: begin
                        if (pend) begin
                            ph = 1; kk = 0; adv = 0;
                        end else begin
                            if (v) begin e_dout = d & m_mask; e_data = 1; end
                            else e_dout = m_idle;
                            if (m_len[3] == 0) adv = 0;
                        end
                    end
                endcase
                if (adv) begin
                    kk++;
                    if (kk == m_len[ph]) begin
                        ph = (ph == 3) ? 1 : ph + 1;
                        kk = 0;
                    end
                end
            end else begin
                e_push = 0;
            end
            if (old_ph != 3) pend = 0;
            else if (p && pend) pend = 0;
            else if (r) pend = 1;
        end
    endtask

    // ------------------------------------------------------------------
    // driver: one clock of stimulus, ready checked before the edge,
    // registered outputs checked after it
    // ------------------------------------------------------------------
    task automatic cycle(input bit p, input bit r, input bit v, input bit c,
                         input logic [31:0] d);
        bit exp_ready;
        logic [31:0] pay;
        @(negedge CLK);
        DOPULL = p; RETRAIN = r; DIN_VALID = v; CLR = c; DIN = d;
        #1;
        exp_ready = p && !c && (ph == 3) && !pend;
        check("din_ready", {31'b0, obs_ready()}, {31'b0, exp_ready});
        if (exp_ready && v) exp_q.push_back(d & m_mask);
        model_step(p, r, v, c, d);
        @(posedge CLK);
        #1;
        check("dopush",    {31'b0, obs_push()}, {31'b0, e_push});
        check("dout",      obs_dout(),          e_dout);
        check("dout_data", {31'b0, obs_data()}, {31'b0, e_data});
        check("phy_init",  {31'b0, obs_phy()},  {31'b0, e_phy});
        if (obs_push() && obs_data()) begin
            if (exp_q.size() == 0) begin
                check("payload_extra", obs_dout(), 32'hxxxx_xxxx);
            end else begin
                pay = exp_q.pop_front();
                check("payload", obs_dout(), pay);
            end
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, $urandom());
    endtask

    task automatic pull_until(input int tph, input int tk, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (ph == tph && kk == tk) break;
            cycle(1, 0, $urandom_range(0, 1), 0, $urandom());
        end
    endtask

    task automatic async_reset_a();
        @(negedge CLK);
        #2;
        rst_a = 1'b1;
        #1;
        check("rst_dopush",    {31'b0, push_a}, 32'h0);
        check("rst_dout",      dout_a,          32'h0);
        check("rst_dout_data", {31'b0, data_a}, 32'h0);
        check("rst_phy_init",  {31'b0, phy_a},  32'h0);
        check("rst_din_ready", {31'b0, ready_a}, 32'h0);
        model_reset();
        @(negedge CLK);
        DOPULL = 0; RETRAIN = 0; CLR = 0;
        rst_a = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // test sequence
    // ------------------------------------------------------------------
    initial begin
        int n_phy, n_train, n_nopush, n_zero_push;
        set_params_a();
        model_reset();
        #12;
        rst_a = 1'b0;
        idle_cycle();
        idle_cycle();

        // power-up training sequence with continuous pulls
        n_phy = 0; n_train = 0; n_nopush = 0; n_zero_push = 0;
        for (int i = 0; i < 64 + 256 + 1; i++) begin
            cycle(1, 0, 0, 0, $urandom());
            if (!push_a) n_nopush++;
            if (phy_a) n_phy++;
            if (push_a && dout_a == 32'hAAAA_AAAA) n_train++;
            if (push_a && dout_a == 32'h0) n_zero_push++;
        end
        check("init_nopush_count", n_nopush, 64);
        check("train_count", n_train, 190);
        check("guard_zero_count", n_zero_push, 66);
        check("phy_init_count", n_phy, 126);
        check("align_word", dout_a, 32'hF731_8CEF);

        // full data phase, pulls gapped one in three, valid random
        for (int i = 0; i < 3 * 1024 + 30; i++)
            cycle((i % 3) == 0, 0, $urandom_range(0, 1), 0, $urandom());

        // retrain pulse in the middle of data
        pull_until(3, 0, 400);
        for (int i = 0; i < 20; i++) cycle(1, 0, 1, 0, $urandom());
        cycle(1, 1, 1, 0, $urandom());
        for (int i = 0; i < 40; i++) cycle(1, 0, 1, 0, $urandom());

        // retrain together with the last data pull
        pull_until(3, 1023, 1500);
        cycle(1, 1, 1, 0, $urandom());
        for (int i = 0; i < 40; i++) cycle(1, 0, 1, 0, $urandom());

        // random mix including rare retrain and clear
        for (int i = 0; i < 2500; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 799) == 0, $urandom());

        // clear in the middle of DELAY_ADJUST, then INIT length again
        pull_until(1, 100, 3000);
        cycle(1, 0, 1, 1, $urandom());
        n_nopush = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(1, 0, 1, 0, $urandom());
            if (!push_a) n_nopush++;
        end
        check("clr_init_len", n_nopush, 64);

        // asynchronous reset in the middle of DELAY_ADJUST
        pull_until(1, 120, 400);
        async_reset_a();
        for (int i = 0; i < 80; i++) cycle(1, 0, 1, 0, $urandom());

        // small configuration on instance B
        rst_a = 1'b1;
        sel = 1'b1;
        set_params_b();
        model_reset();
        @(negedge CLK);
        DOPULL = 0; RETRAIN = 0; CLR = 0;
        rst_b = 1'b0;
        idle_cycle();
        for (int i = 0; i < 60; i++) cycle(1, 0, $urandom_range(0, 1), 0, $urandom());
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 299) == 0, $urandom());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
